// File: rtl/sd_pkg.sv
// Shared definitions for the SD CMD-line physical layer: FSM states, CRC7 polynomial,
// frame lengths and response-type codes.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_RESP,
    ST_RECEIVE,
    ST_DONE
  } sd_state_e;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int unsigned HEAD_BITS  = 40;
  localparam int unsigned SHORT_BITS = 48;
  localparam int unsigned LONG_BITS  = 136;

  // Codes 01 and 11 both select a 48-bit response.
  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_LONG = 2'b10;

  function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic din);
    logic fb;
    fb = crc[6] ^ din;
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1) accumulator; clear has priority over enable.
module sd_crc7 (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       data,
  output logic [6:0] crc
);
  import sd_pkg::*;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= crc7_next(crc, data);
    end
  end

endmodule

// File: rtl/sd_cmd_phys.sv
// SD CMD-line physical layer: serialises a 48-bit command with CRC7, then captures a
// 48/136-bit response or flags a timeout, returning the result via strobe/ack.
module sd_cmd_phys #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TURNAROUND     = 2,
  parameter int unsigned CNT_W          = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         strobe_in,
  input  logic [39:0]  cmd_in,
  input  logic [1:0]   resp_type,
  input  logic         timeout_enable,
  input  logic         ack_in,
  input  logic         cmd_pin_in,
  output logic         cmd_pin_out,
  output logic         cmd_pin_oe,
  output logic         serial_ready,
  output logic         strobe_out,
  output logic         ack_out,
  output logic [135:0] cmd_out,
  output logic         time_out,
  output logic         crc_error
);
  import sd_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] HEAD_LAST       = CNT_W'(HEAD_BITS - 1);
  localparam logic [CNT_W-1:0] TX_CRC_HI       = CNT_W'(SHORT_BITS - 2);
  localparam logic [CNT_W-1:0] TX_LAST         = CNT_W'(SHORT_BITS - 1);
  localparam logic [CNT_W-1:0] WAIT_FIRST      = CNT_W'(TURNAROUND);
  localparam logic [CNT_W-1:0] WAIT_LIMIT      = CNT_W'(TURNAROUND + TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] RX_SHORT_LAST   = CNT_W'(SHORT_BITS - 1);
  localparam logic [CNT_W-1:0] RX_LONG_LAST    = CNT_W'(LONG_BITS - 1);
  localparam logic [CNT_W-1:0] RX_SHORT_CRC_HI = CNT_W'(SHORT_BITS - 9);
  localparam logic [CNT_W-1:0] RX_LONG_CRC_LO  = CNT_W'(LONG_BITS - 128);
  localparam logic [CNT_W-1:0] RX_LONG_CRC_HI  = CNT_W'(LONG_BITS - 9);

  sd_state_e        state, next_state;
  logic [39:0]      head_q;
  logic [1:0]       resp_q;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       crc;
  logic             crc_clear, crc_en, crc_din;
  logic             resp_long, resp_none, start_seen, wait_expired;
  logic [CNT_W-1:0] rx_last_idx, crc_lo, crc_hi;
  logic [2:0]       crc_bit_sel;

  sd_crc7 u_crc (
    .clock  (clock),
    .reset  (reset),
    .clear  (crc_clear),
    .enable (crc_en),
    .data   (crc_din),
    .crc    (crc)
  );

  always_comb begin
    resp_long    = (resp_q == RESP_LONG);
    resp_none    = (resp_q == RESP_NONE);
    rx_last_idx  = resp_long ? RX_LONG_LAST : RX_SHORT_LAST;
    crc_lo       = resp_long ? RX_LONG_CRC_LO : '0;
    crc_hi       = resp_long ? RX_LONG_CRC_HI : RX_SHORT_CRC_HI;
    start_seen   = (state == ST_WAIT_RESP) && (cnt >= WAIT_FIRST) && !cmd_pin_in;
    wait_expired = timeout_enable && (cnt == WAIT_LIMIT);
    crc_bit_sel  = 3'(TX_CRC_HI - cnt);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (strobe_in) next_state = ST_SEND;
      ST_SEND: if (cnt == TX_LAST) next_state = resp_none ? ST_DONE : ST_WAIT_RESP;
      ST_WAIT_RESP: begin
        // A start bit seen in the expiry cycle takes precedence over the timeout.
        if (start_seen) next_state = ST_RECEIVE;
        else if (wait_expired) next_state = ST_DONE;
      end
      ST_RECEIVE: if (cnt == rx_last_idx) next_state = ST_DONE;
      ST_DONE: if (ack_in) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // The CRC engine is cleared when a transaction starts and again after the end bit,
  // so the same instance serves the transmitted head and the received frame.
  always_comb begin
    cmd_pin_oe  = 1'b0;
    cmd_pin_out = 1'b1;
    crc_clear   = 1'b0;
    crc_en      = 1'b0;
    crc_din     = cmd_pin_in;
    case (state)
      ST_IDLE: crc_clear = strobe_in;
      ST_SEND: begin
        cmd_pin_oe = 1'b1;
        crc_clear  = (cnt == TX_LAST);
        if (cnt <= HEAD_LAST) begin
          cmd_pin_out = head_q[39];
          crc_en      = 1'b1;
          crc_din     = head_q[39];
        end else if (cnt != TX_LAST) begin
          cmd_pin_out = crc[crc_bit_sel];
        end
      end
      ST_WAIT_RESP: crc_en = start_seen && !resp_long;
      ST_RECEIVE:   crc_en = (cnt >= crc_lo) && (cnt <= crc_hi);
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q       <= '0;
      resp_q       <= '0;
      cnt          <= '0;
      cmd_out      <= '0;
      time_out     <= 1'b0;
      crc_error    <= 1'b0;
      serial_ready <= 1'b0;
      strobe_out   <= 1'b0;
      ack_out      <= 1'b0;
    end else begin
      serial_ready <= (next_state == ST_IDLE);
      strobe_out   <= (next_state == ST_DONE);
      ack_out      <= (state == ST_DONE) && ack_in;
      case (state)
        ST_IDLE: begin
          if (strobe_in) begin
            head_q    <= cmd_in;
            resp_q    <= resp_type;
            cnt       <= '0;
            cmd_out   <= '0;
            time_out  <= 1'b0;
            crc_error <= 1'b0;
          end
        end
        ST_SEND: begin
          head_q <= {head_q[38:0], 1'b0};
          cnt    <= (cnt == TX_LAST) ? '0 : cnt + CNT_ONE;
        end
        ST_WAIT_RESP: begin
          // With the timeout disabled the counter parks at the limit instead of wrapping.
          if (start_seen) begin
            cmd_out <= {cmd_out[134:0], cmd_pin_in};
            cnt     <= CNT_ONE;
          end else if (wait_expired) begin
            time_out <= 1'b1;
          end else if (cnt != WAIT_LIMIT) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_RECEIVE: begin
          cmd_out <= {cmd_out[134:0], cmd_pin_in};
          cnt     <= cnt + CNT_ONE;
          if (cnt == rx_last_idx) begin
            crc_error <= (cmd_out[6:0] != crc) || !cmd_pin_in;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
